coo_enc_hls_axis_block_detector: RTL and testbench
==================================================

// Module: coo_enc_hls_axis_block_detector
// PURPOSE
// - Source of per-channel AXIS block flags consumed by the coo_enc deadlock monitors (axis_block_sigs).
// - Watches NUM_CH AXI-Stream handshakes around HLS sub-instances and flags any channel stalled for
//   STALL_THRESH consecutive cycles.
// - Also reports the first channel to block, for the deadlock report path.
// PARAMETERS
// - NUM_CH        4   number of monitored AXIS channels
// - STALL_THRESH  16  consecutive stall cycles before a flag asserts (>=1)
// - CNT_W         8   stall counter width; must satisfy 2^CNT_W > STALL_THRESH
// PORTS
// - clock            in   1               clock; all logic on rising edge
// - reset            in   1               synchronous, active-high
// - ch_tvalid        in   NUM_CH          per-channel TVALID (passive tap)
// - ch_tready        in   NUM_CH          per-channel TREADY (passive tap)
// - ch_dir           in   NUM_CH          static; 0 = read side (instance consumes), 1 = write side (produces)
// - inst_idle        in   1               owning instance idle; clears all non-sticky tracking
// - clear            in   1               single-cycle pulse; clears flags, counters, first-block capture
// - axis_block_sigs  out  NUM_CH          per-channel blocked flag, to monitor axis_block_sigs
// - block_any        out  1               OR of axis_block_sigs
// - first_vld        out  1               first_ch holds a valid capture
// - first_ch         out  $clog2(NUM_CH)  index of first channel to block
// BEHAVIOUR
// - Reset: axis_block_sigs=0, block_any=0, first_vld=0, first_ch=0; all counters 0; all channels IDLE.
// - Stall condition, channel i:
//   - dir=0: stall = ch_tready[i] & ~ch_tvalid[i] (waiting on empty input).
//   - dir=1: stall = ch_tvalid[i] & ~ch_tready[i] (waiting on full output).
//   - Transfer (tvalid&tready) and neither-asserted are both non-stall.
// - Per-channel FSM: IDLE -> COUNT -> BLOCKED.
//   - IDLE: stall -> COUNT, cnt<=1.
//   - COUNT: stall -> cnt<=cnt+1; if cnt+1==STALL_THRESH -> BLOCKED. Non-stall -> IDLE, cnt<=0.
//   - BLOCKED: flag=1. cnt saturates at STALL_THRESH, no wrap. Non-stall -> IDLE, cnt<=0, flag drops next cycle.
//   - STALL_THRESH=1: IDLE goes straight to BLOCKED on the first stall cycle.
// - Latency: flag registered; rises on the edge ending the STALL_THRESH-th consecutive stall cycle
//   (visible the next cycle). Falls 1 cycle after the first non-stall cycle.
// - block_any: registered OR of next-state flags; always coincident with axis_block_sigs.
// - First-block capture:
//   - When first_vld=0 and >=1 channel enters BLOCKED: first_vld<=1, first_ch<=lowest entering index.
//   - Simultaneous entry: lowest index wins.
//   - Held while any flag is set; first_vld<=0 on the cycle all flags are 0.
// - Priority, highest first: reset > clear > inst_idle > per-channel stall logic.
//   - clear and inst_idle in the same cycle as a stall: that stall is not counted.
//   - inst_idle=1: all channels IDLE, cnt=0, flags 0, first_vld=0.
// - Reset mid-count or mid-block: everything returns to reset values on the next edge; no residue.
// - ch_dir is sampled every cycle. Changing it while active is unsupported; result is undefined but
//   must not hang the FSM.
// CONFIGURATION
// - Macro COO_ENC_AXIS_BLOCK_STICKY_EN.
// - Defined:
//   - BLOCKED is terminal until clear or reset; non-stall and inst_idle do not drop the flag.
//   - first_ch/first_vld hold until clear; the capture is for post-mortem readout.
// - Undefined: behaviour exactly as above (flags track live stall state).
// - Ports are identical in both builds.
// TESTING
// - Reset then idle: tvalid=tready=0 for 100 cycles -> axis_block_sigs=0, first_vld=0.
// - ch0 dir=0, tready=1/tvalid=0 for 16 cycles -> axis_block_sigs[0]=1 from cycle 17, first_ch=0.
//   Drop tready -> flag 0 one cycle later.
// - ch2 dir=1, tvalid=1/tready=0 for 15 cycles, 1 transfer, 15 more stall -> flag never asserts
//   (counter restarts at the transfer).
// - ch1 and ch3 dir=1, stalls start on the same cycle -> both flags rise together,
//   first_ch=1, block_any=1.
// - ch0 BLOCKED; pulse inst_idle -> all flags 0 next cycle (non-sticky).
//   STICKY build: stall released -> flag stays 1 until clear pulse.
// - Reset asserted at stall cycle 10 of 16, then stall resumes -> flag rises only after 16 fresh cycles.

Source files
------------

// File: rtl/coo_enc_hls_axis_block_detector_if.sv
// AXI-Stream handshake tap bundle for the block detector: per-channel TVALID/TREADY
// plus the static per-channel direction strap.
interface coo_enc_hls_axis_block_detector_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] ch_tvalid;
    logic [NUM_CH-1:0] ch_tready;
    logic [NUM_CH-1:0] ch_dir;

    modport master (output ch_tvalid, output ch_tready, output ch_dir);
    modport slave  (input  ch_tvalid, input  ch_tready, input  ch_dir);
endinterface

// File: rtl/coo_enc_hls_axis_block_detector.sv
// Per-channel AXIS stall detector feeding the coo_enc deadlock monitors, with first-block capture.
// Build option: define COO_ENC_AXIS_BLOCK_STICKY_EN to make block flags and the capture sticky until clear.
module coo_enc_hls_axis_block_detector #(
    parameter int NUM_CH       = 4,
    parameter int STALL_THRESH = 16,
    parameter int CNT_W        = 8,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                    clock,
    input  logic                                    reset,
    coo_enc_hls_axis_block_detector_if.slave        axis_if,
    input  logic                                    inst_idle_i,
    input  logic                                    clear_i,
    output logic [NUM_CH-1:0]                       axis_block_sigs_o,
    output logic                                    block_any_o,
    output logic                                    first_vld_o,
    output logic [CH_W-1:0]                         first_ch_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COUNT   = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

`ifdef COO_ENC_AXIS_BLOCK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic [1:0]        state_q [NUM_CH];
    logic [1:0]        state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] flag_q;
    logic [NUM_CH-1:0] flag_d;
    logic [NUM_CH-1:0] entering;
    logic              block_any_q;
    logic              first_vld_q;
    logic              first_vld_d;
    logic [CH_W-1:0]   first_ch_q;
    logic [CH_W-1:0]   first_ch_d;
    logic [CH_W-1:0]   lowest_entering;

    // Read side waits on an empty input, write side waits on a full output.
    assign stall = (axis_if.ch_dir  & axis_if.ch_tvalid & ~axis_if.ch_tready)
                 | (~axis_if.ch_dir & axis_if.ch_tready & ~axis_if.ch_tvalid);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: hold-value defaults first so no path leaves a next-state unassigned (no latches).
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (clear_i) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else if (inst_idle_i) begin
                if (!(STICKY && state_q[i] == ST_BLOCKED)) begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (stall[i]) begin
                            cnt_d[i]   = CNT_W'(1);
                            state_d[i] = (THRESH == CNT_W'(1)) ? ST_BLOCKED : ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (stall[i]) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            if (cnt_q[i] + CNT_W'(1) == THRESH) state_d[i] = ST_BLOCKED;
                        end else begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end
                    end
                    ST_BLOCKED: begin
                        if (stall[i]) begin
                            cnt_d[i] = THRESH;
                        end else if (!STICKY) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end
                    end
                    default: begin
                        // Unused encoding: recover rather than lock up.
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            flag_d[i] = (state_d[i] == ST_BLOCKED);
        end
    end

    assign entering = flag_d & ~flag_q;

    always_comb begin
        lowest_entering = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (entering[i]) lowest_entering = CH_W'(i);
        end
    end

    always_comb begin
        first_vld_d = first_vld_q;
        first_ch_d  = first_ch_q;
        if (clear_i) begin
            first_vld_d = 1'b0;
            first_ch_d  = '0;
        end else if (!STICKY && inst_idle_i) begin
            first_vld_d = 1'b0;
        end else if (!first_vld_q && (|entering)) begin
            first_vld_d = 1'b1;
            first_ch_d  = lowest_entering;
        end else if (!STICKY && !(|flag_d)) begin
            first_vld_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop is reset explicitly.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            flag_q      <= '0;
            block_any_q <= 1'b0;
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            flag_q      <= flag_d;
            block_any_q <= |flag_d;
            first_vld_q <= first_vld_d;
            first_ch_q  <= first_ch_d;
        end
    end

    assign axis_block_sigs_o = flag_q;
    assign block_any_o       = block_any_q;
    assign first_vld_o       = first_vld_q;
    assign first_ch_o        = first_ch_q;

endmodule

// File: tb/tb_coo_enc_hls_axis_block_detector.sv
// Testbench for coo_enc_hls_axis_block_detector: directed scenarios plus randomized traffic,
// checked against a run-length reference model of the stall rules.
module tb_coo_enc_hls_axis_block_detector;

    localparam int NUM_CH = 4;
    localparam int THRESH = 16;

`ifdef COO_ENC_AXIS_BLOCK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              inst_idle;
    logic              clear;
    logic [NUM_CH-1:0] axis_block_sigs;
    logic              block_any;
    logic              first_vld;
    logic [1:0]        first_ch;

    coo_enc_hls_axis_block_detector_if #(.NUM_CH(NUM_CH)) axis_if ();

    coo_enc_hls_axis_block_detector #(
        .NUM_CH       (NUM_CH),
        .STALL_THRESH (THRESH),
        .CNT_W        (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .axis_if           (axis_if),
        .inst_idle_i       (inst_idle),
        .clear_i           (clear),
        .axis_block_sigs_o (axis_block_sigs),
        .block_any_o       (block_any),
        .first_vld_o       (first_vld),
        .first_ch_o        (first_ch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: length of the current unbroken stall run per channel.
    int                run_len [NUM_CH];
    logic [NUM_CH-1:0] m_flags;
    logic              m_fv;
    logic [1:0]        m_fc;

    function automatic logic [7:0] expected_vec();
        return {m_flags, |m_flags, m_fv, m_fc};
    endfunction

    function automatic logic [7:0] observed_vec();
        return {axis_block_sigs, block_any, first_vld, first_ch};
    endfunction

    task automatic model_update();
        logic [NUM_CH-1:0] stall_now;
        logic [NUM_CH-1:0] nf;
        logic [NUM_CH-1:0] enter;
        stall_now = 0;
        nf        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (axis_if.ch_dir[i]) stall_now[i] = axis_if.ch_tvalid[i] && !axis_if.ch_tready[i];
            else                   stall_now[i] = axis_if.ch_tready[i] && !axis_if.ch_tvalid[i];
        end
        if (reset || clear) begin
            for (int i = 0; i < NUM_CH; i++) run_len[i] = 0;
            m_flags = 0;
            m_fv    = 0;
            m_fc    = 0;
        end else if (inst_idle) begin
            for (int i = 0; i < NUM_CH; i++) run_len[i] = 0;
            if (!STICKY) begin
                m_flags = 0;
                m_fv    = 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                run_len[i] = stall_now[i] ? run_len[i] + 1 : 0;
                nf[i]      = (run_len[i] >= THRESH) || (STICKY && m_flags[i]);
            end
            enter = nf & ~m_flags;
            if (!m_fv && enter != 0) begin
                m_fv = 1;
                for (int i = NUM_CH - 1; i >= 0; i--) if (enter[i]) m_fc = 2'(i);
            end else if (!STICKY && nf == 0) begin
                m_fv = 0;
            end
            m_flags = nf;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [3:0] tv, input logic [3:0] tr, input logic [3:0] dir);
        axis_if.ch_tvalid = tv;
        axis_if.ch_tready = tr;
        axis_if.ch_dir    = dir;
    endtask

    task automatic do_reset();
        reset = 1; inst_idle = 0; clear = 0;
        drive(4'h0, 4'h0, 4'h0);
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (observed_vec() !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", observed_vec(), 8'h00);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < 100; k++) step();
        checks++;
        if (axis_block_sigs !== 4'h0 || first_vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_100 got flags=%h fv=%b exp flags=0 fv=0", axis_block_sigs, first_vld);
        end
    endtask

    task automatic test_ch0_block();
        do_reset();
        drive(4'h0, 4'h1, 4'h0);
        for (int k = 1; k <= THRESH; k++) begin
            step();
            checks++;
            if (axis_block_sigs[0] !== (k == THRESH)) begin
                errors++;
                $display("FAIL ch0_block edge %0d got %b exp %b", k, axis_block_sigs[0], k == THRESH);
            end
        end
        checks++;
        if (first_vld !== 1'b1 || first_ch !== 2'd0 || block_any !== 1'b1) begin
            errors++;
            $display("FAIL ch0_first got fv=%b fc=%0d any=%b exp fv=1 fc=0 any=1", first_vld, first_ch, block_any);
        end
        drive(4'h0, 4'h0, 4'h0);
        step();
        checks++;
        if (axis_block_sigs[0] !== STICKY) begin
            errors++;
            $display("FAIL ch0_release got %b exp %b", axis_block_sigs[0], STICKY);
        end
    endtask

    task automatic test_transfer_restart();
        do_reset();
        for (int k = 0; k < 31; k++) begin
            if (k == 15) drive(4'h4, 4'h4, 4'h4);
            else         drive(4'h4, 4'h0, 4'h4);
            step();
            checks++;
            if (axis_block_sigs[2] !== 1'b0 || observed_vec() !== expected_vec()) begin
                errors++;
                $display("FAIL ch2_restart edge %0d got %h exp %h", k + 1, observed_vec(), expected_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(4'hA, 4'h0, 4'hA);
        for (int k = 0; k < THRESH; k++) step();
        checks++;
        if (axis_block_sigs !== 4'hA || first_ch !== 2'd1 || block_any !== 1'b1 || first_vld !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous got flags=%h fc=%0d any=%b fv=%b exp flags=a fc=1 any=1 fv=1",
                     axis_block_sigs, first_ch, block_any, first_vld);
        end
    endtask

    task automatic test_inst_idle();
        do_reset();
        drive(4'h0, 4'h1, 4'h0);
        for (int k = 0; k < THRESH; k++) step();
        inst_idle = 1;
        step();
        inst_idle = 0;
        checks++;
        if (axis_block_sigs[0] !== STICKY) begin
            errors++;
            $display("FAIL inst_idle got %b exp %b", axis_block_sigs[0], STICKY);
        end
        drive(4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (observed_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL idle_released got %h exp %h", observed_vec(), expected_vec());
        end
        clear = 1;
        step();
        clear = 0;
        checks++;
        if (observed_vec() !== 8'h00) begin
            errors++;
            $display("FAIL clear_pulse got %h exp %h", observed_vec(), 8'h00);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(4'h0, 4'h1, 4'h0);
        for (int k = 0; k < 10; k++) step();
        reset = 1;
        step();
        reset = 0;
        for (int k = 1; k <= THRESH; k++) begin
            step();
            checks++;
            if (axis_block_sigs[0] !== (k == THRESH)) begin
                errors++;
                $display("FAIL reset_mid edge %0d got %b exp %b", k, axis_block_sigs[0], k == THRESH);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] dir;
        logic [3:0] hot;
        logic [3:0] tv;
        logic [3:0] tr;
        do_reset();
        for (int seg = 0; seg < 20; seg++) begin
            dir = 4'($urandom);
            hot = 4'($urandom);
            for (int k = 0; k < 100; k++) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (hot[i] && $urandom_range(0, 39) != 0) begin
                        tv[i] = dir[i];
                        tr[i] = !dir[i];
                    end else begin
                        tv[i] = 1'($urandom);
                        tr[i] = 1'($urandom);
                    end
                end
                drive(tv, tr, dir);
                inst_idle = ($urandom_range(0, 199) == 0);
                clear     = ($urandom_range(0, 299) == 0);
                reset     = ($urandom_range(0, 499) == 0);
                step();
                checks++;
                if (observed_vec() !== expected_vec()) begin
                    errors++;
                    $display("FAIL random cyc %0d got %h exp %h", cyc, observed_vec(), expected_vec());
                end
            end
        end
        reset = 0; inst_idle = 0; clear = 0;
    endtask

    initial begin
        reset = 1; inst_idle = 0; clear = 0;
        drive(4'h0, 4'h0, 4'h0);
        for (int i = 0; i < NUM_CH; i++) run_len[i] = 0;
        m_flags = 0; m_fv = 0; m_fc = 0;
        test_reset();
        test_idle();
        test_ch0_block();
        test_transfer_restart();
        test_simultaneous();
        test_inst_idle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
